// File: rtl/duc_fs4.sv
// duc_fs4 : fs/4 digital up-converter (transmit side of the fs/4 DDC).
//   Takes one complex baseband symbol every 4 Clk_160 cycles, holds it for
//   four output samples (x4 sample-hold interpolation), mixes with an fs/4
//   carrier (+I, -Q, -I, +Q) and emits one rounded, saturated 12-bit real IF
//   sample per cycle. A PRF tag rides with each symbol and emerges on the
//   phase-0 output sample of that symbol.
// Ports:
//   Clk_160        clock (DAC sample rate)
//   Rst            synchronous active-high reset
//   Data_I_in/Q_in 20-bit signed baseband sample
//   Data_valid_in  input valid; transfer on Data_valid_in && Data_ready_out
//   Data_ready_out holding register empty (registered)
//   Prf_in         PRF tag, sampled on a transfer
//   Data_out       12-bit signed IF sample
//   Data_valid_out Data_out valid
//   Prf_out        pulse on phase-0 output of a tagged symbol
//   Underflow      pulse when no symbol is ready at a RUN symbol boundary
//   Underflow_cnt  16-bit saturating underflow count (only with
//                  DUC_UNDERFLOW_STAT_EN defined)
module duc_fs4 #(
  parameter int unsigned OUT_SHIFT = 8,
  parameter int unsigned IDLE_SYMS = 4
) (
  input  logic        Clk_160,
  input  logic        Rst,
  input  logic [19:0] Data_I_in,
  input  logic [19:0] Data_Q_in,
  input  logic        Data_valid_in,
  output logic        Data_ready_out,
  input  logic        Prf_in,
  output logic [11:0] Data_out,
  output logic        Data_valid_out,
  output logic        Prf_out,
  output logic        Underflow
`ifdef DUC_UNDERFLOW_STAT_EN
  ,
  output logic [15:0] Underflow_cnt
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int unsigned CW = $clog2(IDLE_SYMS + 1);
  localparam logic signed [21:0] RND = 22'sd1 <<< (OUT_SHIFT - 1);

  state_t             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [19:0]        hold_re_q, hold_re_d, hold_im_q, hold_im_d;
  logic               hold_prf_q, hold_prf_d, hold_full_q, hold_full_d;
  logic               rdy_q, rdy_d;
  logic [19:0]        act_re_q, act_re_d, act_im_q, act_im_d;
  logic               act_prf_q, act_prf_d;
  logic [CW-1:0]      urun_q, urun_d;
  logic               uflow_q, uflow_d;
  logic signed [20:0] mix_q, mix_d;
  logic               mix_vld_q, mix_vld_d, mix_prf_q, mix_prf_d;
  logic [11:0]        dout_q, dout_d;
  logic               dvld_q, dvld_d, prf_q, prf_d;

  logic               accept, load;
  logic signed [20:0] ext_re, ext_im;
  logic signed [21:0] rsum, shifted;

  // Control: symbol handshake, hold/active registers and RUN/IDLE FSM.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hold_re_d   = hold_re_q;
    hold_im_d   = hold_im_q;
    hold_prf_d  = hold_prf_q;
    hold_full_d = hold_full_q;
    act_re_d    = act_re_q;
    act_im_d    = act_im_q;
    act_prf_d   = act_prf_q;
    urun_d      = urun_q;
    uflow_d     = 1'b0;
    load        = 1'b0;
    accept      = Data_valid_in && rdy_q;

    case (state_q)
      S_IDLE: begin
        phase_d = 2'd0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (hold_full_q) begin
            load   = 1'b1;
            urun_d = '0;
          end else begin
            uflow_d   = 1'b1;
            act_re_d  = '0;
            act_im_d  = '0;
            act_prf_d = 1'b0;
            if (urun_q == CW'(IDLE_SYMS - 1)) begin
              state_d = S_IDLE;
              urun_d  = '0;
            end else begin
              urun_d = urun_q + CW'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      act_re_d    = hold_re_q;
      act_im_d    = hold_im_q;
      act_prf_d   = hold_prf_q;
      hold_full_d = 1'b0;
    end
    // Accept only happens while rdy_q=1, i.e. hold was empty last cycle, so
    // it never coincides with a load of the same holding register.
    if (accept) begin
      hold_re_d   = Data_I_in;
      hold_im_d   = Data_Q_in;
      hold_prf_d  = Prf_in;
      hold_full_d = 1'b1;
    end
    rdy_d = ~hold_full_d;
  end

  // Mixer: fs/4 carrier is the sequence +I, -Q, -I, +Q; 21-bit negation
  // keeps -(-2^19) exact.
  assign ext_re = $signed({act_re_q[19], act_re_q});
  assign ext_im = $signed({act_im_q[19], act_im_q});

  always_comb begin
    mix_d = '0;
    if (state_q == S_RUN) begin
      case (phase_q)
        2'd0:    mix_d = ext_re;
        2'd1:    mix_d = -ext_im;
        2'd2:    mix_d = -ext_re;
        default: mix_d = ext_im;
      endcase
    end
    mix_vld_d = (state_q == S_RUN);
    mix_prf_d = (state_q == S_RUN) && (phase_q == 2'd0) && act_prf_q;
  end

  // Output: round half up, arithmetic shift, saturate to 12 bits.
  assign rsum    = $signed({mix_q[20], mix_q}) + RND;
  assign shifted = rsum >>> OUT_SHIFT;

  always_comb begin
    if (shifted > 22'sd2047)       dout_d = 12'h7FF;
    else if (shifted < -22'sd2048) dout_d = 12'h800;
    else                           dout_d = shifted[11:0];
    if (!mix_vld_q) dout_d = '0;
    dvld_d = mix_vld_q;
    prf_d  = mix_prf_q;
  end

  always_ff @(posedge Clk_160) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      hold_re_q   <= '0;
      hold_im_q   <= '0;
      hold_prf_q  <= 1'b0;
      hold_full_q <= 1'b0;
      rdy_q       <= 1'b0;
      act_re_q    <= '0;
      act_im_q    <= '0;
      act_prf_q   <= 1'b0;
      urun_q      <= '0;
      uflow_q     <= 1'b0;
      mix_q       <= '0;
      mix_vld_q   <= 1'b0;
      mix_prf_q   <= 1'b0;
      dout_q      <= '0;
      dvld_q      <= 1'b0;
      prf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hold_re_q   <= hold_re_d;
      hold_im_q   <= hold_im_d;
      hold_prf_q  <= hold_prf_d;
      hold_full_q <= hold_full_d;
      rdy_q       <= rdy_d;
      act_re_q    <= act_re_d;
      act_im_q    <= act_im_d;
      act_prf_q   <= act_prf_d;
      urun_q      <= urun_d;
      uflow_q     <= uflow_d;
      mix_q       <= mix_d;
      mix_vld_q   <= mix_vld_d;
      mix_prf_q   <= mix_prf_d;
      dout_q      <= dout_d;
      dvld_q      <= dvld_d;
      prf_q       <= prf_d;
    end
  end

`ifdef DUC_UNDERFLOW_STAT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge Clk_160) begin
    if (Rst)                            ucnt_q <= '0;
    else if (uflow_q && (ucnt_q != '1)) ucnt_q <= ucnt_q + 16'd1;
  end

  assign Underflow_cnt = ucnt_q;
`endif

  assign Data_ready_out = rdy_q;
  assign Data_out       = dout_q;
  assign Data_valid_out = dvld_q;
  assign Prf_out        = prf_q;
  assign Underflow      = uflow_q;

endmodule
